lp_decimator_signed: RTL and testbench

LP_DECIMATOR_SIGNED -- requirements
Module: lp_decimator_signed

---
 rtl/lp_decimator_signed_pkg.sv | 48 ++++
 rtl/lp_decimator_signed.sv | 96 +++++++++
 tb/tb_lp_decimator_signed.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lp_decimator_signed_pkg.sv
// Shared filter package: width derivation and signed saturation helpers
// used by the low-pass filter stage and the decimator that follows it.
package lp_decimator_signed_pkg;

    // Working width of the saturation helpers. It must exceed any accumulator
    // width in use (IN_DATA_BITS + DECIM_SHIFT_BITS <= 63).
    localparam int SAT_W = 64;

    // Accumulator width that makes a sum of 2^shift_bits in_bits-wide
    // signed samples unable to overflow.
    function automatic int acc_bits(input int in_bits, input int shift_bits);
        return in_bits + shift_bits;
    endfunction

    // Largest value representable in out_bits signed bits.
    function automatic logic signed [SAT_W-1:0] sat_max(input int out_bits);
        return (64'sd1 <<< (out_bits - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in out_bits signed bits.
    function automatic logic signed [SAT_W-1:0] sat_min(input int out_bits);
        return -(64'sd1 <<< (out_bits - 1));
    endfunction

    // Clamp a wide signed value into the out_bits signed range.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] value,
        input int                      out_bits
    );
        logic signed [SAT_W-1:0] clamped;
        clamped = value;
        if (value > sat_max(out_bits)) begin
            clamped = sat_max(out_bits);
        end else if (value < sat_min(out_bits)) begin
            clamped = sat_min(out_bits);
        end
        return clamped;
    endfunction

    // True when sat_signed would change the value.
    function automatic logic sat_clamps(
        input logic signed [SAT_W-1:0] value,
        input int                      out_bits
    );
        return (value > sat_max(out_bits)) || (value < sat_min(out_bits));
    endfunction

endpackage

// File: rtl/lp_decimator_signed.sv
// Block-average decimator: sums 2^DECIM_SHIFT_BITS CE samples, divides by
// an arithmetic shift (floor), saturates to OUT_DATA_BITS and presents the
// result on a valid/ready output register with sticky status flags.
//
// Output handshake: OUT_VALID=1 means OUT_VALUE holds a result not yet
// taken; a transfer happens on every rising edge where OUT_VALID=1 and
// OUT_READY=1. OUT_VALUE does not change while OUT_VALID=1 unless a new
// block result replaces it (counted as an overrun when it was not taken).
module lp_decimator_signed
    import lp_decimator_signed_pkg::*;
#(
    parameter int IN_DATA_BITS     = 30,
    parameter int OUT_DATA_BITS    = 24,
    parameter int DECIM_SHIFT_BITS = 4
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            CE,
    input  logic signed [IN_DATA_BITS-1:0]  IN_VALUE,
    output logic signed [OUT_DATA_BITS-1:0] OUT_VALUE,
    output logic                            OUT_VALID,
    input  logic                            OUT_READY,
    output logic                            SATURATED,
    output logic                            OVERRUN
);

    localparam int ACC_BITS = acc_bits(IN_DATA_BITS, DECIM_SHIFT_BITS);

    // Counter value of the last sample in a block (N-1).
    localparam logic [DECIM_SHIFT_BITS-1:0] CNT_LAST = {DECIM_SHIFT_BITS{1'b1}};
    localparam logic [DECIM_SHIFT_BITS-1:0] CNT_ONE  = DECIM_SHIFT_BITS'(1);

    logic signed [ACC_BITS-1:0]         acc;
    logic [DECIM_SHIFT_BITS-1:0]        cnt;

    logic signed [ACC_BITS-1:0]         in_ext;
    logic signed [ACC_BITS-1:0]         sum;
    logic signed [ACC_BITS-1:0]         shifted;
    logic signed [SAT_W-1:0]            shifted_wide;
    logic signed [OUT_DATA_BITS-1:0]    result;
    logic                               result_clamped;
    logic                               block_end;
    logic                               taken;

    // Datapath: running sum, floor divide by N, then clamp to output range.
    always_comb begin
        in_ext         = {{DECIM_SHIFT_BITS{IN_VALUE[IN_DATA_BITS-1]}}, IN_VALUE};
        sum            = acc + in_ext;
        shifted        = sum >>> DECIM_SHIFT_BITS;
        shifted_wide   = {{(SAT_W-ACC_BITS){shifted[ACC_BITS-1]}}, shifted};
        result         = OUT_DATA_BITS'(sat_signed(shifted_wide, OUT_DATA_BITS));
        result_clamped = sat_clamps(shifted_wide, OUT_DATA_BITS);
        block_end      = CE && (cnt == CNT_LAST);
        taken          = OUT_VALID && OUT_READY;
    end

    // Accumulate CE samples; the last sample of a block restarts the sum.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc <= '0;
            cnt <= '0;
        end else if (CE) begin
            if (cnt == CNT_LAST) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Output register, handshake and sticky status flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            OUT_VALUE <= '0;
            OUT_VALID <= 1'b0;
            SATURATED <= 1'b0;
            OVERRUN   <= 1'b0;
        end else if (block_end) begin
            // A new result always lands; losing an untaken one is flagged.
            OUT_VALUE <= result;
            OUT_VALID <= 1'b1;
            if (result_clamped) begin
                SATURATED <= 1'b1;
            end
            if (OUT_VALID && !OUT_READY) begin
                OVERRUN <= 1'b1;
            end
        end else if (taken) begin
            // Value is left in place after the transfer; only valid drops.
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lp_decimator_signed.sv
// Directed bench for lp_decimator_signed: a table of constant-input blocks
// with hand-computed results, plus hand-written multi-cycle sequences for
// rounding, overwrite/overrun, CE gating and mid-block reset.
module tb_lp_decimator_signed;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset     = 1'b1;
    logic                ce        = 1'b0;
    logic                out_ready = 1'b0;
    logic signed [29:0]  in_value  = '0;

    // Default-parameter instance (24-bit output).
    logic signed [23:0]  out_value;
    logic                out_valid;
    logic                saturated;
    logic                overrun;

    // Wide-output instance (30-bit output), shares all inputs.
    logic signed [29:0]  w_out_value;
    logic                w_out_valid;
    logic                w_saturated;
    logic                w_overrun;

    lp_decimator_signed dut (
        .CLK       (clk),
        .RESET     (reset),
        .CE        (ce),
        .IN_VALUE  (in_value),
        .OUT_VALUE (out_value),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .SATURATED (saturated),
        .OVERRUN   (overrun)
    );

    lp_decimator_signed #(
        .IN_DATA_BITS     (30),
        .OUT_DATA_BITS    (30),
        .DECIM_SHIFT_BITS (4)
    ) dut_wide (
        .CLK       (clk),
        .RESET     (reset),
        .CE        (ce),
        .IN_VALUE  (in_value),
        .OUT_VALUE (w_out_value),
        .OUT_VALID (w_out_valid),
        .OUT_READY (out_ready),
        .SATURATED (w_saturated),
        .OVERRUN   (w_overrun)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic signed [63:0] actual,
                         input logic signed [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic feed(input logic signed [29:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            ce       = 1'b1;
            in_value = v;
            tick();
        end
        ce = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    logic [23:0] exp_q[$];
    logic        sb_on = 1'b0;

    // A transfer happens at the next rising edge when valid and ready are
    // both high half a cycle before it.
    always @(negedge clk) begin
        if (sb_on && !reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 64'sd1, 64'sd0);
            end else begin
                logic signed [23:0] e;
                e = exp_q.pop_front();
                check("sb_value", out_value, e);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic signed [29:0] in_value;
        logic signed [23:0] exp_out;
        logic               exp_sat;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    // Watchdog: nothing here waits on the DUT, but never hang regardless.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int bad;
        int pulses;

        vecs[0]  = '{30'sd0,           24'sd0,        1'b0};
        vecs[1]  = '{30'sd5,           24'sd5,        1'b0};
        vecs[2]  = '{-30'sd7,          -24'sd7,       1'b0};
        vecs[3]  = '{30'sd8388607,     24'sd8388607,  1'b0};
        vecs[4]  = '{30'sd8388608,     24'sd8388607,  1'b1};
        vecs[5]  = '{-30'sd8388608,    -24'sd8388608, 1'b0};
        vecs[6]  = '{-30'sd8388609,    -24'sd8388608, 1'b1};
        vecs[7]  = '{30'sd109377165,   24'sd8388607,  1'b1};
        vecs[8]  = '{-30'sd218754330,  -24'sd8388608, 1'b1};
        vecs[9]  = '{30'sd536870911,   24'sd8388607,  1'b1};
        vecs[10] = '{-30'sd536870912,  -24'sd8388608, 1'b1};

        // Reset state.
        tick();
        check("reset_out_value", out_value, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_saturated", saturated, 0);
        check("reset_overrun",   overrun,   0);
        reset = 1'b0;

        // Table: one constant-input block per vector, consumer always ready.
        out_ready = 1'b1;
        for (int v = 0; v < NVEC; v++) begin
            do_reset();
            sb_on = 1'b1;
            exp_q.push_back(vecs[v].exp_out);
            feed(vecs[v].in_value, 15);
            check("tbl_valid_before_end", out_valid, 0);
            feed(vecs[v].in_value, 1);
            check("tbl_out_value", out_value, vecs[v].exp_out);
            check("tbl_out_valid", out_valid, 1);
            check("tbl_saturated", saturated, vecs[v].exp_sat);
            check("tbl_overrun",   overrun,   0);
            check("tbl_wide_value", w_out_value, vecs[v].in_value);
            check("tbl_wide_sat",   w_saturated, 0);
            tick();
            check("tbl_valid_cleared", out_valid, 0);
        end
        sb_on = 1'b0;
        check("sb_queue_drained", exp_q.size(), 0);

        // Wide output, CE held high: one-cycle valid pulse every 16 clocks.
        do_reset();
        out_ready = 1'b1;
        ce        = 1'b1;
        in_value  = 30'sd109377165;
        bad       = 0;
        pulses    = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (w_out_valid !== ((i % 16) == 15)) bad++;
            if (w_out_valid === 1'b1) begin
                pulses++;
                if (w_out_value !== 30'sd109377165) bad++;
            end
        end
        ce = 1'b0;
        check("pulse_pattern", bad, 0);
        check("pulse_count", pulses, 3);
        check("pulse_wide_sat", w_saturated, 0);
        check("pulse_wide_overrun", w_overrun, 0);

        // Positive then negative saturation; saturated is sticky.
        do_reset();
        feed(30'sd109377165, 16);
        check("sat_pos_value", out_value, 8388607);
        check("sat_pos_flag", saturated, 1);
        feed(-30'sd218754330, 16);
        check("sat_neg_value", out_value, -8388608);
        check("sat_neg_flag_sticky", saturated, 1);
        check("sat_neg_valid", out_valid, 1);

        // Floor rounding: +1,-2 alternating sums to -8 -> -1.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ce       = 1'b1;
            in_value = (i % 2 == 0) ? 30'sd1 : -30'sd2;
            tick();
        end
        ce = 1'b0;
        check("floor_alt_value", out_value, -1);
        check("floor_alt_sat", saturated, 0);
        // Sum -1 floors to -1, sum +15 floors to 0.
        do_reset();
        feed(-30'sd1, 1);
        feed(30'sd0, 15);
        check("floor_minus_one", out_value, -1);
        do_reset();
        feed(30'sd15, 1);
        feed(30'sd0, 15);
        check("floor_plus_fifteen", out_value, 0);

        // Overwrite without a taker sets overrun; value changes only on block end.
        do_reset();
        out_ready = 1'b0;
        feed(30'sd100, 16);
        check("ovr_first_valid", out_valid, 1);
        check("ovr_first_value", out_value, 100);
        check("ovr_first_flag", overrun, 0);
        feed(30'sd200, 15);
        check("ovr_hold_value", out_value, 100);
        check("ovr_hold_valid", out_valid, 1);
        feed(30'sd200, 1);
        check("ovr_second_value", out_value, 200);
        check("ovr_second_flag", overrun, 1);
        feed(30'sd200, 8);
        check("ovr_still_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("ovr_valid_cleared", out_valid, 0);
        check("ovr_value_held", out_value, 200);

        // Block end coinciding with a transfer: no overrun, valid stays high.
        do_reset();
        out_ready = 1'b0;
        feed(30'sd300, 16);
        feed(30'sd400, 15);
        out_ready = 1'b1;
        feed(30'sd400, 1);
        check("coinc_value", out_value, 400);
        check("coinc_valid", out_valid, 1);
        check("coinc_overrun", overrun, 0);
        tick();
        check("coinc_valid_cleared", out_valid, 0);

        // CE every other cycle: the 16th sample arrives on clock 32.
        do_reset();
        out_ready = 1'b1;
        in_value  = 30'sd109377165;
        for (int i = 0; i < 32; i++) begin
            ce = (i % 2 == 1);
            tick();
            if (i == 30) check("ce_gap_not_yet", w_out_valid, 0);
        end
        ce = 1'b0;
        check("ce_gap_valid", w_out_valid, 1);
        check("ce_gap_wide_value", w_out_value, 109377165);
        check("ce_gap_value", out_value, 8388607);

        // Mid-block reset discards the partial sum and clears everything.
        do_reset();
        out_ready = 1'b0;
        feed(30'sd109377165, 16);
        feed(30'sd1000, 7);
        check("rst_pre_valid", out_valid, 1);
        check("rst_pre_sat", saturated, 1);
        reset     = 1'b1;
        ce        = 1'b1;
        in_value  = 30'sd5000;
        out_ready = 1'b1;
        tick();
        check("rst_out_value", out_value, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_saturated", saturated, 0);
        check("rst_overrun", overrun, 0);
        check("rst_wide_value", w_out_value, 0);
        reset = 1'b0;
        feed(30'sd50, 15);
        check("rst_after_15", out_valid, 0);
        feed(30'sd50, 1);
        check("rst_after_16_valid", out_valid, 1);
        check("rst_after_16_value", out_value, 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
